// File: rtl/vcve2_data_mem_arbiter_if.sv
// vcve2_data_mem_arbiter_if: requester-side and memory-side handshakes of the
// data-memory arbiter. The slave modport is the arbiter's own view; master is
// the view of whatever surrounds it (VRF ports, LSU and the external bus).
interface vcve2_data_mem_arbiter_if #(
    parameter int unsigned NumVec = 2
);
    // vector register-file requesters
    logic [NumVec-1:0]       vreq_i;
    logic [NumVec-1:0]       vwe_i;
    logic [NumVec-1:0][3:0]  vbe_i;
    logic [NumVec-1:0][31:0] vaddr_i;
    logic [NumVec-1:0][31:0] vwdata_i;
    logic [NumVec-1:0]       vgnt_o;
    logic [NumVec-1:0]       vrvalid_o;
    logic [NumVec-1:0]       verr_o;

    // scalar LSU requester
    logic                    lsu_req_i;
    logic                    lsu_we_i;
    logic [3:0]              lsu_be_i;
    logic [31:0]             lsu_addr_i;
    logic [31:0]             lsu_wdata_i;
    logic                    lsu_gnt_o;
    logic                    lsu_rvalid_o;
    logic                    lsu_err_o;

    // response data shared by every requester
    logic [31:0]             rdata_o;

    // core data-memory port
    logic                    data_req_o;
    logic                    data_we_o;
    logic [3:0]              data_be_o;
    logic [31:0]             data_addr_o;
    logic [31:0]             data_wdata_o;
    logic                    data_gnt_i;
    logic                    data_rvalid_i;
    logic                    data_err_i;
    logic [31:0]             data_rdata_i;

    modport slave (
        input  vreq_i, vwe_i, vbe_i, vaddr_i, vwdata_i,
        output vgnt_o, vrvalid_o, verr_o,
        input  lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
        output lsu_gnt_o, lsu_rvalid_o, lsu_err_o,
        output rdata_o,
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
    );

    modport master (
        output vreq_i, vwe_i, vbe_i, vaddr_i, vwdata_i,
        input  vgnt_o, vrvalid_o, verr_o,
        output lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i,
        input  lsu_gnt_o, lsu_rvalid_o, lsu_err_o,
        input  rdata_o,
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_err_i, data_rdata_i
    );
endinterface

// File: rtl/vcve2_data_mem_arbiter.sv
// vcve2_data_mem_arbiter: shares the core data-memory port between NumVec
// vector register-file ports and the scalar LSU. The LSU has fixed priority,
// vector ports rotate round-robin, and only one transaction is in flight.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no transaction; pick the next owner from the live requests
//   REQ   | owner's request is on the memory port, waiting for data_gnt_i
//   RESP  | grant given, waiting for data_rvalid_i to route back to owner
//
// owner_q holds 0..NumVec-1 for a vector port and NumVec for the LSU.
module vcve2_data_mem_arbiter #(
    parameter int unsigned NumVec = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    vcve2_data_mem_arbiter_if.slave bus,
    output logic                    busy_o
);
    localparam int NV = int'(NumVec);
    localparam int unsigned OwnW = $clog2(NumVec + 1);
    localparam int unsigned RrW  = (NumVec > 1) ? $clog2(NumVec) : 1;
    localparam logic [OwnW-1:0] OwnLsu = OwnW'(NumVec);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [OwnW-1:0]   owner_q, owner_d;
    logic [RrW-1:0]    rr_q, rr_d;

    logic [NumVec-1:0] sel_vec;
    logic              sel_lsu;
    logic              own_req;
    logic              own_we;
    logic [3:0]        own_be;
    logic [31:0]       own_addr;
    logic [31:0]       own_wdata;
    logic              any_req;
    logic              pick_found;
    logic [OwnW-1:0]   pick_idx;
    logic              hs;

    // Decode the current owner into one-hot select lines.
    always_comb begin
        sel_vec = '0;
        sel_lsu = (owner_q == OwnLsu);
        for (int i = 0; i < NV; i++) begin
            sel_vec[i] = (owner_q == OwnW'(i));
        end
    end

    // Mux the owner's request fields; these are what REQ puts on the bus.
    always_comb begin
        own_req   = 1'b0;
        own_we    = 1'b0;
        own_be    = '0;
        own_addr  = '0;
        own_wdata = '0;
        if (sel_lsu) begin
            own_req   = bus.lsu_req_i;
            own_we    = bus.lsu_we_i;
            own_be    = bus.lsu_be_i;
            own_addr  = bus.lsu_addr_i;
            own_wdata = bus.lsu_wdata_i;
        end
        for (int i = 0; i < NV; i++) begin
            if (sel_vec[i]) begin
                own_req   = bus.vreq_i[i];
                own_we    = bus.vwe_i[i];
                own_be    = bus.vbe_i[i];
                own_addr  = bus.vaddr_i[i];
                own_wdata = bus.vwdata_i[i];
            end
        end
    end

    // Round-robin search: first requesting vector port at or after rr_q.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        any_req    = bus.lsu_req_i | (|bus.vreq_i);
        for (int k = 0; k < NV; k++) begin
            for (int i = 0; i < NV; i++) begin
                if (!pick_found && bus.vreq_i[i] && (i == ((int'(rr_q) + k) % NV))) begin
                    pick_found = 1'b1;
                    pick_idx   = OwnW'(i);
                end
            end
        end
    end

    // Next-state, owner/pointer update and all handshake outputs.
    always_comb begin
        state_d           = state_q;
        owner_d           = owner_q;
        rr_d              = rr_q;
        hs                = 1'b0;
        bus.data_req_o    = 1'b0;
        bus.data_we_o     = 1'b0;
        bus.data_be_o     = '0;
        bus.data_addr_o   = '0;
        bus.data_wdata_o  = '0;
        bus.vgnt_o        = '0;
        bus.vrvalid_o     = '0;
        bus.verr_o        = '0;
        bus.lsu_gnt_o     = 1'b0;
        bus.lsu_rvalid_o  = 1'b0;
        bus.lsu_err_o     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    if (bus.lsu_req_i) begin
                        owner_d = OwnLsu;
                    end else if (pick_found) begin
                        owner_d = pick_idx;
                    end
                    state_d = REQ;
                end
            end
            REQ: begin
                bus.data_req_o   = own_req;
                bus.data_we_o    = own_we;
                bus.data_be_o    = own_be;
                bus.data_addr_o  = own_addr;
                bus.data_wdata_o = own_wdata;
                hs               = own_req & bus.data_gnt_i;
                if (hs) begin
                    bus.lsu_gnt_o = sel_lsu;
                    bus.vgnt_o    = sel_vec;
                    // The LSU's win must not disturb the vector rotation.
                    if (!sel_lsu) begin
                        rr_d = RrW'((int'(owner_q) + 1) % NV);
                    end
                    state_d = RESP;
                end else if (!own_req) begin
                    // Owner withdrew before the grant: drop it silently.
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (bus.data_rvalid_i) begin
                    bus.lsu_rvalid_o = sel_lsu;
                    bus.lsu_err_o    = sel_lsu & bus.data_err_i;
                    bus.vrvalid_o    = sel_vec;
                    bus.verr_o       = sel_vec & {NumVec{bus.data_err_i}};
                    state_d          = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read data is broadcast; each requester qualifies it with its rvalid.
    assign bus.rdata_o = bus.data_rdata_i;
    assign busy_o      = (state_q != IDLE);

    // State, owner and round-robin registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end
endmodule

// File: tb/tb_vcve2_data_mem_arbiter.sv
// tb_vcve2_data_mem_arbiter: directed transactions against the arbiter with a
// small memory responder; expected grants and responses are queued up front
// and a monitor pops and compares them whenever the DUT presents one.
module tb_vcve2_data_mem_arbiter;
    localparam int NV  = 2;
    localparam int LSU = NV;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic busy_o;

    always #5 clk_i = ~clk_i;

    vcve2_data_mem_arbiter_if #(.NumVec(NV)) bus ();

    vcve2_data_mem_arbiter #(.NumVec(NV)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus),
        .busy_o (busy_o)
    );

    typedef struct {
        int          who;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        int          who;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    gnt_t exp_gnt[$];
    rsp_t exp_rsp[$];

    int n_checks = 0;
    int n_errors = 0;

    int stall_cycles = 0;
    bit rsp_enable   = 1'b1;
    bit stray_rvalid = 1'b0;
    int rem [NV+1];

    function automatic logic [31:0] mem_rdata(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return a ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return a[31:28] == 4'hE;
    endfunction

    function automatic logic granted(input int who);
        if (who == LSU) return bus.lsu_gnt_o;
        return bus.vgnt_o[who];
    endfunction

    function automatic logic responded(input int who);
        if (who == LSU) return bus.lsu_rvalid_o;
        return bus.vrvalid_o[who];
    endfunction

    function automatic logic [95:0] all_outs();
        return {busy_o, bus.vgnt_o, bus.vrvalid_o, bus.verr_o,
                bus.lsu_gnt_o, bus.lsu_rvalid_o, bus.lsu_err_o,
                bus.data_req_o, bus.data_we_o, bus.data_be_o,
                bus.data_addr_o, bus.data_wdata_o};
    endfunction

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_req(input int who, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (who == LSU) begin
            bus.lsu_req_i   = 1'b1;
            bus.lsu_we_i    = we;
            bus.lsu_be_i    = be;
            bus.lsu_addr_i  = addr;
            bus.lsu_wdata_i = wdata;
        end else begin
            bus.vreq_i[who]   = 1'b1;
            bus.vwe_i[who]    = we;
            bus.vbe_i[who]    = be;
            bus.vaddr_i[who]  = addr;
            bus.vwdata_i[who] = wdata;
        end
    endtask

    task automatic clr_req(input int who);
        if (who == LSU) bus.lsu_req_i = 1'b0;
        else            bus.vreq_i[who] = 1'b0;
    endtask

    task automatic expect_txn(input int who, input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata);
        exp_gnt.push_back('{who, we, be, addr, wdata});
        exp_rsp.push_back('{who, mem_rdata(addr), mem_err(addr)});
    endtask

    // One isolated transaction, also checking grant and response latency.
    task automatic do_one(input int who, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata, input int stall);
        int lat;
        bit got;
        stall_cycles = stall;
        expect_txn(who, we, be, addr, wdata);
        @(posedge clk_i); #1;
        set_req(who, we, be, addr, wdata);
        lat = 0; got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk_i);
            lat++;
            got = granted(who);
        end
        check("gnt_latency", lat, 2 + stall);
        @(posedge clk_i); #1;
        clr_req(who);
        lat = 0; got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk_i);
            lat++;
            got = responded(who);
        end
        check("rsp_latency", lat, 1);
        @(posedge clk_i); #1;
        check("busy_after", busy_o, 0);
    endtask

    // Requesters with rem[who] > 0 keep requesting until that many grants.
    task automatic run_multi();
        int cyc;
        bit done;
        bit g [NV+1];
        cyc = 0; done = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge clk_i);
            cyc++;
            for (int w = 0; w <= NV; w++) g[w] = granted(w);
            @(posedge clk_i); #1;
            done = !busy_o;
            for (int w = 0; w <= NV; w++) begin
                if (g[w] && rem[w] > 0) begin
                    rem[w]--;
                    if (rem[w] == 0) clr_req(w);
                end
                if (rem[w] != 0) done = 1'b0;
            end
        end
        check("multi_done", done, 1);
    endtask

    // Memory responder: grants after stall_cycles, answers the next cycle.
    initial begin : mem_model
        bit   hs_m;
        bit   req_seen;
        int   stall_left;
        logic [31:0] last_addr;
        bus.data_gnt_i    = 1'b0;
        bus.data_rvalid_i = 1'b0;
        bus.data_err_i    = 1'b0;
        bus.data_rdata_i  = '0;
        req_seen = 1'b0; stall_left = 0; last_addr = '0;
        forever begin
            @(posedge clk_i); #1;
            hs_m = bus.data_gnt_i && rst_ni;
            bus.data_gnt_i    = 1'b0;
            bus.data_rvalid_i = 1'b0;
            bus.data_err_i    = 1'b0;
            if (hs_m && rsp_enable) begin
                bus.data_rvalid_i = 1'b1;
                bus.data_rdata_i  = mem_rdata(last_addr);
                bus.data_err_i    = mem_err(last_addr);
            end else if (stray_rvalid) begin
                bus.data_rvalid_i = 1'b1;
                bus.data_rdata_i  = 32'hBAD0_BAD0;
                stray_rvalid      = 1'b0;
            end
            if (bus.data_req_o) begin
                if (!req_seen) begin
                    req_seen   = 1'b1;
                    stall_left = stall_cycles;
                end
                if (stall_left == 0) begin
                    bus.data_gnt_i = 1'b1;
                    last_addr      = bus.data_addr_o;
                    req_seen       = 1'b0;
                end else begin
                    stall_left--;
                end
            end
        end
    end

    // Monitor: compare every grant/response the DUT presents to the queues.
    initial begin : monitor
        int   g_cnt, g_who, r_cnt, r_who;
        gnt_t eg;
        rsp_t er;
        logic [NV:0] ev;
        forever begin
            @(negedge clk_i);
            g_cnt = 0; g_who = -1; r_cnt = 0; r_who = -1;
            for (int w = 0; w <= NV; w++) begin
                if (granted(w))   begin g_cnt++; g_who = w; end
                if (responded(w)) begin r_cnt++; r_who = w; end
            end
            check("one_hot", (g_cnt <= 1) && (r_cnt <= 1), 1);
            if (g_cnt == 1) begin
                if (exp_gnt.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL gnt_unexpected: got grant to %0d expected none", g_who);
                end else begin
                    eg = exp_gnt.pop_front();
                    check("gnt_who", g_who, eg.who);
                    check("gnt_fields",
                          {bus.data_req_o, bus.data_we_o, bus.data_be_o, bus.data_addr_o, bus.data_wdata_o},
                          {1'b1, eg.we, eg.be, eg.addr, eg.wdata});
                end
            end else if (bus.data_req_o && exp_gnt.size() != 0) begin
                check("stall_fields",
                      {bus.data_we_o, bus.data_be_o, bus.data_addr_o, bus.data_wdata_o},
                      {exp_gnt[0].we, exp_gnt[0].be, exp_gnt[0].addr, exp_gnt[0].wdata});
            end
            if (!busy_o) begin
                check("idle_bus_zero",
                      {bus.data_req_o, bus.data_we_o, bus.data_be_o, bus.data_addr_o, bus.data_wdata_o}, 0);
            end
            if (r_cnt == 1) begin
                if (exp_rsp.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL rsp_unexpected: got rvalid to %0d expected none", r_who);
                end else begin
                    er = exp_rsp.pop_front();
                    ev = '0;
                    if (er.err) ev[er.who] = 1'b1;
                    check("rsp_who", r_who, er.who);
                    check("rsp_rdata", bus.rdata_o, er.rdata);
                    check("rsp_err", {bus.lsu_err_o, bus.verr_o}, ev);
                end
            end else begin
                check("err_without_rvalid", {bus.lsu_err_o, bus.verr_o}, 0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin : stim
        int lat;
        bit got;
        rst_ni          = 1'b0;
        bus.vreq_i      = '0;
        bus.vwe_i       = '0;
        bus.vbe_i       = '0;
        bus.vaddr_i     = '0;
        bus.vwdata_i    = '0;
        bus.lsu_req_i   = 1'b0;
        bus.lsu_we_i    = 1'b0;
        bus.lsu_be_i    = '0;
        bus.lsu_addr_i  = '0;
        bus.lsu_wdata_i = '0;
        for (int w = 0; w <= NV; w++) rem[w] = 0;

        repeat (2) @(negedge clk_i);
        check("reset_outputs", all_outs(), 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // single vector read
        do_one(0, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 0);

        // scalar priority over vector port 1, then port 1
        expect_txn(LSU, 1'b0, 4'hF, 32'h0000_0200, 32'h0);
        expect_txn(1,   1'b0, 4'hF, 32'h0000_0300, 32'h0);
        stall_cycles = 0;
        @(posedge clk_i); #1;
        set_req(LSU, 1'b0, 4'hF, 32'h0000_0200, 32'h0);
        set_req(1,   1'b0, 4'hF, 32'h0000_0300, 32'h0);
        rem[LSU] = 1; rem[1] = 1;
        run_multi();

        // round-robin with both vector ports requesting continuously
        expect_txn(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0);
        expect_txn(1, 1'b0, 4'hF, 32'h0000_2000, 32'h0);
        expect_txn(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0);
        expect_txn(1, 1'b0, 4'hF, 32'h0000_2000, 32'h0);
        @(posedge clk_i); #1;
        set_req(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0);
        set_req(1, 1'b0, 4'hF, 32'h0000_2000, 32'h0);
        rem[0] = 2; rem[1] = 2;
        run_multi();

        // write with five grant-stall cycles
        do_one(0, 1'b1, 4'hF, 32'h0000_0400, 32'h1234_5678, 5);

        // scalar partial write with a short stall
        do_one(LSU, 1'b1, 4'h3, 32'h0000_0500, 32'hCAFE_F00D, 2);

        // error routed to vector port 1
        do_one(1, 1'b0, 4'hF, 32'hE000_0040, 32'h0, 0);

        // reset while waiting for the response, then a stray rvalid
        rsp_enable   = 1'b0;
        stall_cycles = 0;
        exp_gnt.push_back('{0, 1'b0, 4'hF, 32'h0000_0600, 32'h0});
        @(posedge clk_i); #1;
        set_req(0, 1'b0, 4'hF, 32'h0000_0600, 32'h0);
        lat = 0; got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk_i);
            lat++;
            got = granted(0);
        end
        check("rst_test_gnt", got, 1);
        @(posedge clk_i); #1;
        clr_req(0);
        @(negedge clk_i);
        check("resp_busy", busy_o, 1);
        #2 rst_ni = 1'b0;
        #1 check("async_reset_outputs", all_outs(), 0);
        @(posedge clk_i); #1;
        rst_ni       = 1'b1;
        rsp_enable   = 1'b1;
        stray_rvalid = 1'b1;
        repeat (4) @(posedge clk_i);
        #1 check("stray_ignored_idle", busy_o, 0);

        // normal service after the reset
        do_one(1, 1'b0, 4'hF, 32'h0000_0700, 32'h0, 1);

        repeat (3) @(posedge clk_i);
        check("gnt_queue_empty", exp_gnt.size(), 0);
        check("rsp_queue_empty", exp_rsp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
